mmio_store_capture: RTL and testbench

- Sits directly downstream of the single-cycle core's data-memory write port (MemWrite/DataAdr/WriteData, plus PCO).
- Filters stores that fall in a small MMIO window and buffers them in a show-ahead FIFO.
- Drains the FIFO to a slow peripheral/host over a valid/ready interface.
- Latches the program's end-of-test result store (address 252) as a hardware pass/fail status, so a run is self-checking in silicon as well as in simulation.

---
 rtl/mmio_store_capture.sv | 97 +++++++++
 tb/tb_mmio_store_capture.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/mmio_store_capture.sv
// mmio_store_capture: snoops the core's data-memory write port, queues stores
// that land in the MMIO window in a show-ahead FIFO drained over valid/ready,
// and latches the first end-of-test result store as a pass/fail status.
module mmio_store_capture #(
  parameter int          DEPTH      = 4,
  parameter logic [31:0] MMIO_BASE  = 32'h0000_00F0,
  parameter logic [31:0] MMIO_MASK  = 32'hFFFF_FFF0,
  parameter logic [31:0] RESULT_ADR = 32'h0000_00FC,
  parameter logic [31:0] PASS_VALUE = 32'd22
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     MemWrite,
  input  logic [31:0]              DataAdr,
  input  logic [31:0]              WriteData,
  input  logic [31:0]              PCO,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               out_adr,
  output logic [31:0]              out_data,
  output logic [31:0]              out_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     done,
  output logic [31:0]              result,
  output logic                     pass
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];

  // entry storage: address nibble, store data, issuing PC
  logic [3:0]    adr_mem  [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          hit, deq, enq, res_hit;

  // window decode and handshake qualification; a full FIFO still accepts
  // a store when the head leaves in the same cycle
  always_comb begin
    hit     = MemWrite && ((DataAdr & MMIO_MASK) == MMIO_BASE);
    res_hit = MemWrite && (DataAdr == RESULT_ADR) && !done;
    deq     = out_valid && out_ready;
    enq     = hit && ((cnt < FULL) || deq);
  end

  assign out_valid = (cnt != '0);
  assign count     = cnt;
  assign out_adr   = adr_mem[rd_ptr];
  assign out_data  = data_mem[rd_ptr];
  assign out_pc    = pc_mem[rd_ptr];

  // entry writes; storage needs no reset since out_valid gates its use
  always_ff @(posedge clk) begin
    if (reset && enq) begin
      adr_mem[wr_ptr]  <= DataAdr[3:0];
      data_mem[wr_ptr] <= WriteData;
      pc_mem[wr_ptr]   <= PCO;
    end
  end

  // pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (hit && !enq) overflow <= 1'b1;
    end
  end

  // first result store wins; later ones are ignored until reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      done   <= 1'b0;
      result <= '0;
      pass   <= 1'b0;
    end else if (res_hit) begin
      done   <= 1'b1;
      result <= WriteData;
      pass   <= (WriteData == PASS_VALUE);
    end
  end

endmodule

// File: tb/tb_mmio_store_capture.sv
// Scoreboard bench for mmio_store_capture: a queue-based model updated at each
// rising edge, and a monitor on the falling edge comparing every output.
module tb_mmio_store_capture;
  localparam int DEPTH = 4;

  typedef struct {
    logic [3:0]  adr;
    logic [31:0] data;
    logic [31:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr, WriteData, PCO;
  logic        out_valid, out_ready;
  logic [3:0]  out_adr;
  logic [31:0] out_data, out_pc;
  logic [$clog2(DEPTH):0] count;
  logic        overflow, done, pass;
  logic [31:0] result;

  mmio_store_capture #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .PCO(PCO), .out_valid(out_valid),
    .out_ready(out_ready), .out_adr(out_adr), .out_data(out_data),
    .out_pc(out_pc), .count(count), .overflow(overflow), .done(done),
    .result(result), .pass(pass)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  ent_t sb[$];
  int   mcnt = 0;
  bit   movf = 0, mdone = 0, mpass = 0, armed = 0;
  logic [31:0] mres = '0;
  bit   m_deq, m_hit, m_enq;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  // reference model: window as an address range, FIFO as a queue
  always @(posedge clk) begin
    if (!reset) begin
      sb.delete();
      mcnt = 0; movf = 0; mdone = 0; mres = '0; mpass = 0; armed = 1;
    end else if (armed) begin
      m_deq = (mcnt > 0) && out_ready;
      m_hit = MemWrite && DataAdr >= 32'hF0 && DataAdr <= 32'hFF;
      m_enq = m_hit && (mcnt < DEPTH || m_deq);
      if (MemWrite && DataAdr == 32'd252 && !mdone) begin
        mdone = 1; mres = WriteData; mpass = (WriteData == 32'd22);
      end
      if (m_enq) sb.push_back('{DataAdr[3:0], WriteData, PCO});
      if (m_hit && !m_enq) movf = 1;
      mcnt = mcnt + (m_enq ? 1 : 0) - (m_deq ? 1 : 0);
    end
  end

  // monitor: status every cycle, head contents while valid, pop on handshake
  always @(negedge clk) begin
    if (armed) begin
      chk("count", 32'(count), 32'(mcnt));
      chk("out_valid", 32'(out_valid), 32'(mcnt != 0));
      chk("overflow", 32'(overflow), 32'(movf));
      chk("done", 32'(done), 32'(mdone));
      chk("result", result, mres);
      chk("pass", 32'(pass), 32'(mpass));
      if (mcnt != 0) begin
        if (sb.size() == 0) begin
          chk("scoreboard_nonempty", 32'(sb.size()), 32'(mcnt));
        end else begin
          chk("out_adr", 32'(out_adr), 32'(sb[0].adr));
          chk("out_data", out_data, sb[0].data);
          chk("out_pc", out_pc, sb[0].pc);
          if (reset && out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic cyc(input logic we, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] p, input logic rdy);
    reset = 1'b1; MemWrite = we; DataAdr = a; WriteData = d; PCO = p; out_ready = rdy;
    @(posedge clk); #1;
  endtask

  // reset cycle with a competing result store and ready to prove priority
  task automatic rst_cyc();
    reset = 1'b0; MemWrite = 1'b1; DataAdr = 32'hFC; WriteData = 32'd22;
    PCO = 32'h4; out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b0; MemWrite = 1'b0; DataAdr = '0; WriteData = '0; PCO = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // outside the window
    cyc(1, 32'h40, 32'h11, 32'h0, 1);
    cyc(1, 32'h100, 32'h22, 32'h4, 1);
    cyc(1, 32'hEC, 32'h33, 32'h8, 1);
    cyc(0, 0, 0, 0, 1);
    // single store then single handshake
    cyc(1, 32'hF4, 32'h1234, 32'h20, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    // overflow by six stores, then drain
    for (int i = 1; i <= 6; i++) cyc(1, 32'hF0, i, 32'h100 + 4 * i, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1);
    // full with simultaneous dequeue and enqueue
    rst_cyc();
    for (int i = 1; i <= 4; i++) cyc(1, 32'hF0 + i, 32'h50 + i, 32'h200 + 4 * i, 0);
    cyc(1, 32'hF8, 32'd9, 32'h300, 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1);
    // passing result, then a later result store ignored
    cyc(1, 32'hFC, 32'd22, 32'h400, 0);
    cyc(1, 32'hFC, 32'd5, 32'h404, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);
    // failing result, reset mid-drain
    rst_cyc();
    cyc(1, 32'hFC, 32'd7, 32'h500, 0);
    cyc(1, 32'hF0, 32'd1, 32'h504, 0);
    cyc(0, 0, 0, 0, 1);
    rst_cyc();
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    // randomized traffic
    rst_cyc();
    for (int i = 0; i < 800; i++) begin
      logic [31:0] a;
      case ($urandom_range(0, 3))
        0: a = 32'hF0 | 32'($urandom_range(0, 15));
        1: a = 32'hFC;
        2: a = 32'($urandom_range(32'hE0, 32'h10F));
        default: a = $urandom;
      endcase
      if ($urandom_range(0, 199) == 0) rst_cyc();
      else cyc(1'($urandom_range(0, 1)), a,
               ($urandom_range(0, 3) == 0) ? 32'd22 : $urandom, $urandom,
               1'($urandom_range(0, 2) != 0));
    end
    cyc(0, 0, 0, 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
